// File: rtl/param_ram_pkg.sv
// param_ram_pkg: state encoding and depth helper shared by the param_ram files
package param_ram_pkg;
  typedef enum logic [1:0] {S_CLEAR = 2'd0, S_IDLE = 2'd1, S_BURST = 2'd2} state_e;
  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/param_ram_array.sv
// ram_array: byte-enable synchronous-write, synchronous-read storage
module ram_array
  import param_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic                    re_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [depth(ADDR_WIDTH)];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i)
      for (int i = 0; i < DATA_WIDTH / 8; i++)
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
  end
  // only the read register is reset; the array itself is zeroed by the clear sweep
  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/param_ram.sv
// param_ram: single-port RAM with byte enables, zero-fill after reset and wrapping burst reads
module param_ram
  import param_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    wena,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic                    burst,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid,
  output logic                    busy
);
  localparam int DEPTH = depth(ADDR_WIDTH);
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d, mem_addr;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    valid_q, accept, rd, mem_we, mem_re;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  assign accept = state_q == S_IDLE && ena;
  assign rd     = accept && !wena;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= mem_re;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = S_IDLE;
    end else if (state_q == S_BURST) begin
      ptr_d = ptr_q + 1'b1;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == LEN_WIDTH'(1)) state_d = S_IDLE;
    end else if (rd && burst && len != '0) begin
      state_d = S_BURST;
      ptr_d   = addr + 1'b1;
      cnt_d   = len;
    end
  end
  // clear sweep and bursts drive the array from the pointer, requests from addr
  always_comb begin
    mem_we    = !rst && (state_q == S_CLEAR || (accept && wena));
    mem_re    = state_q == S_BURST || rd;
    mem_be    = state_q == S_CLEAR ? '1 : be;
    mem_wdata = state_q == S_CLEAR ? '0 : din;
    mem_addr  = state_q == S_IDLE ? addr : ptr_q;
  end
  assign busy       = state_q != S_IDLE;
  assign dout_valid = valid_q;
  ram_array #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk    (clk),
    .rst    (rst),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .be_i   (mem_be),
    .addr_i (mem_addr),
    .wdata_i(mem_wdata),
    .rdata_o(dout)
  );
endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: directed checks of param_ram at default size and at 16x8
module tb_param_ram;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst0, ena0, wena0, burst0, dv0, busy0;
  logic [3:0] be0, len0;
  logic [4:0] addr0;
  logic [31:0] din0, dout0;
  logic rst1, ena1, wena1, burst1, dv1, busy1;
  logic [1:0] be1;
  logic [3:0] len1;
  logic [2:0] addr1;
  logic [15:0] din1, dout1;
  int n_chk = 0;
  int n_fail = 0;
  param_ram u0 (
    .clk(clk), .rst(rst0), .ena(ena0), .wena(wena0), .be(be0), .burst(burst0), .len(len0),
    .addr(addr0), .din(din0), .dout(dout0), .dout_valid(dv0), .busy(busy0)
  );
  param_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) u1 (
    .clk(clk), .rst(rst1), .ena(ena1), .wena(wena1), .be(be1), .burst(burst1), .len(len1),
    .addr(addr1), .din(din1), .dout(dout1), .dout_valid(dv1), .busy(busy1)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle0();
    ena0 = 0; wena0 = 0; burst0 = 0; len0 = 0; be0 = 0; addr0 = 0; din0 = 0;
  endtask
  task automatic idle1();
    ena1 = 0; wena1 = 0; burst1 = 0; len1 = 0; be1 = 0; addr1 = 0; din1 = 0;
  endtask
  task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
    ena0 = 1; wena0 = 1; burst0 = 0; addr0 = a; din0 = d; be0 = b;
    step();
    idle0();
  endtask
  task automatic rd0(input logic [4:0] a, output logic [31:0] d, output logic v);
    ena0 = 1; wena0 = 0; burst0 = 0; addr0 = a;
    step();
    d = dout0; v = dv0;
    idle0();
  endtask
  task automatic wr1(input logic [2:0] a, input logic [15:0] d, input logic [1:0] b);
    ena1 = 1; wena1 = 1; burst1 = 0; addr1 = a; din1 = d; be1 = b;
    step();
    idle1();
  endtask
  task automatic wait_clear0(output int c);
    c = 0;
    while (busy0 && c < 100) begin c++; step(); end
  endtask
  task automatic test_reset();
    int c;
    rst0 = 1;
    idle0();
    repeat (3) step();
    n_chk++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy0); end
    n_chk++; if (dout0 !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout0); end
    n_chk++; if (dv0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dv0); end
    rst0 = 0;
    wait_clear0(c);
    n_chk++; if (c !== 32) begin n_fail++; $display("FAIL clear_len: got %0d want 32", c); end
  endtask
  task automatic test_zero_fill();
    logic [31:0] d;
    logic v;
    for (int a = 0; a < 32; a++) begin
      rd0(5'(a), d, v);
      n_chk++;
      if (d !== 32'h0 || v !== 1'b1) begin
        n_fail++; $display("FAIL zero_fill[%0d]: got %h/%b want 00000000/1", a, d, v);
      end
    end
  endtask
  task automatic test_byte_en();
    logic [31:0] d;
    logic v;
    wr0(7, 32'hDEADBEEF, 4'b1111);
    n_chk++; if (dv0 !== 1'b0) begin n_fail++; $display("FAIL write_valid: got %b want 0", dv0); end
    wr0(7, 32'h11223344, 4'b0101);
    rd0(7, d, v);
    n_chk++; if (d !== 32'hDE22BE44 || v !== 1'b1) begin n_fail++; $display("FAIL byte_en: got %h/%b want de22be44/1", d, v); end
    step();
    n_chk++; if (dv0 !== 1'b0 || dout0 !== 32'hDE22BE44) begin n_fail++; $display("FAIL read_hold: got %h/%b want de22be44/0", dout0, dv0); end
    wr0(7, 32'hFFFFFFFF, 4'b0000);
    rd0(7, d, v);
    n_chk++; if (d !== 32'hDE22BE44) begin n_fail++; $display("FAIL be_zero: got %h want de22be44", d); end
  endtask
  task automatic test_burst_wrap();
    logic [31:0] e [4];
    logic [31:0] d;
    logic v;
    int nb = 0;
    e = '{32'hA, 32'hB, 32'hC, 32'hD};
    wr0(30, 32'hA, 4'hF); wr0(31, 32'hB, 4'hF); wr0(0, 32'hC, 4'hF); wr0(1, 32'hD, 4'hF);
    ena0 = 1; wena0 = 0; burst0 = 1; len0 = 3; addr0 = 30;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        ena0 = 1; wena0 = 1; burst0 = 0; addr0 = 5; din0 = 32'hFFFFFFFF; be0 = 4'hF;
      end else idle0();
      n_chk++;
      if (dout0 !== e[k] || dv0 !== 1'b1) begin
        n_fail++; $display("FAIL burst_word[%0d]: got %h/%b want %h/1", k, dout0, dv0, e[k]);
      end
      if (busy0) nb++;
      step();
    end
    n_chk++; if (nb !== 3) begin n_fail++; $display("FAIL burst_busy: got %0d want 3", nb); end
    n_chk++; if (dv0 !== 1'b0) begin n_fail++; $display("FAIL burst_extra_valid: got %b want 0", dv0); end
    rd0(5, d, v);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL ignored_write: got %h want 00000000", d); end
  endtask
  task automatic test_back_to_back();
    ena0 = 1; wena0 = 0; burst0 = 1; len0 = 1; addr0 = 0;
    step();
    idle0();
    n_chk++; if (dout0 !== 32'hC || busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_w0: got %h/%b want c/1", dout0, busy0); end
    step();
    n_chk++; if (dout0 !== 32'hD || dv0 !== 1'b1 || busy0 !== 1'b0) begin n_fail++; $display("FAIL b2b_w1: got %h/%b/%b want d/1/0", dout0, dv0, busy0); end
    ena0 = 1; wena0 = 0; addr0 = 7;
    step();
    n_chk++; if (dout0 !== 32'hDE22BE44 || dv0 !== 1'b1) begin n_fail++; $display("FAIL b2b_read: got %h/%b want de22be44/1", dout0, dv0); end
    burst0 = 1; len0 = 0; addr0 = 31;
    step();
    idle0();
    n_chk++; if (dout0 !== 32'hB || dv0 !== 1'b1 || busy0 !== 1'b0) begin n_fail++; $display("FAIL len0_single: got %h/%b/%b want b/1/0", dout0, dv0, busy0); end
  endtask
  task automatic test_reset_mid_burst();
    logic [31:0] d;
    logic v;
    int c;
    wr0(29, 32'h29292929, 4'hF);
    wr0(20, 32'h12345678, 4'hF);
    ena0 = 1; wena0 = 0; burst0 = 1; len0 = 7; addr0 = 28;
    step();
    idle0();
    n_chk++; if (dout0 !== 32'h0 || dv0 !== 1'b1) begin n_fail++; $display("FAIL mid_w0: got %h/%b want 00000000/1", dout0, dv0); end
    step();
    n_chk++; if (dout0 !== 32'h29292929 || dv0 !== 1'b1) begin n_fail++; $display("FAIL mid_w1: got %h/%b want 29292929/1", dout0, dv0); end
    rst0 = 1;
    step();
    n_chk++; if (dout0 !== 32'h0 || dv0 !== 1'b0 || busy0 !== 1'b1) begin n_fail++; $display("FAIL mid_reset: got %h/%b/%b want 00000000/0/1", dout0, dv0, busy0); end
    step();
    rst0 = 0;
    wait_clear0(c);
    n_chk++; if (c !== 32) begin n_fail++; $display("FAIL mid_clear_len: got %0d want 32", c); end
    rd0(20, d, v);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_gone20: got %h want 00000000", d); end
    rd0(29, d, v);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_gone29: got %h want 00000000", d); end
    rd0(30, d, v);
    n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_gone30: got %h want 00000000", d); end
  endtask
  task automatic test_sweep();
    logic [15:0] e [3];
    int c = 0;
    int nb = 0;
    e = '{16'h6666, 16'h7777, 16'h0F0F};
    n_chk++; if (busy1 !== 1'b1 || dout1 !== 16'h0) begin n_fail++; $display("FAIL sw_reset: got %b/%h want 1/0000", busy1, dout1); end
    rst1 = 0;
    while (busy1 && c < 100) begin c++; step(); end
    n_chk++; if (c !== 8) begin n_fail++; $display("FAIL sw_clear_len: got %0d want 8", c); end
    wr1(6, 16'h6666, 2'b11); wr1(7, 16'h7777, 2'b11); wr1(0, 16'h0F0F, 2'b11); wr1(1, 16'hABCD, 2'b01);
    ena1 = 1; wena1 = 0; addr1 = 1;
    step();
    n_chk++; if (dout1 !== 16'h00CD || dv1 !== 1'b1) begin n_fail++; $display("FAIL sw_byte_en: got %h/%b want 00cd/1", dout1, dv1); end
    burst1 = 1; len1 = 2; addr1 = 6;
    step();
    idle1();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (dout1 !== e[k] || dv1 !== 1'b1) begin
        n_fail++; $display("FAIL sw_burst[%0d]: got %h/%b want %h/1", k, dout1, dv1, e[k]);
      end
      if (busy1) nb++;
      step();
    end
    n_chk++; if (nb !== 2 || dv1 !== 1'b0) begin n_fail++; $display("FAIL sw_burst_end: got busy %0d valid %b want 2/0", nb, dv1); end
  endtask
  initial begin
    rst0 = 1; rst1 = 1;
    idle0(); idle1();
    test_reset();
    test_zero_fill();
    test_byte_en();
    test_burst_wrap();
    test_back_to_back();
    test_reset_mid_burst();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
